// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Byte-addressable data memory with one-cycle registered response.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] mem_write,
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  output logic [31:0] mem_read,
  output logic        ready,
  output logic        err
);

  localparam int c_AW = $clog2(DEPTH_WORDS);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_mem [0:DEPTH_WORDS-1];

  logic [c_AW-1:0] w_idx;
  logic            w_err;
  logic            w_accept;
  logic            w_store;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata;
  logic [31:0]     w_word;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_rdata;
  logic            w_unused;

  assign w_idx    = addr[c_AW+1:2];
  assign w_unused = ^addr[31:c_AW+2];

  always_comb begin
    w_err = 1'b0;
    case (size)
      2'b00:   w_err = 1'b0;
      2'b01:   w_err = addr[0];
      2'b10:   w_err = (addr[1:0] != 2'b00);
      default: w_err = 1'b1;
    endcase
  end

  // Requests are only taken in IDLE and never while reset is asserted.
  assign w_accept = rst && (r_state == S_IDLE) && (wr_en || rd_en);
  assign w_store  = w_accept && wr_en && !w_err;

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = mem_write;
    case (size)
      2'b00: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{mem_write[7:0]}};
      end
      2'b01: begin
        w_be    = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{mem_write[15:0]}};
      end
      2'b10: begin
        w_be    = 4'b1111;
        w_wdata = mem_write;
      end
      default: begin
        w_be    = 4'b0000;
        w_wdata = mem_write;
      end
    endcase
  end

  assign w_word = r_mem[w_idx];

  always_comb begin
    w_byte  = w_word[8*addr[1:0] +: 8];
    w_half  = addr[1] ? w_word[31:16] : w_word[15:0];
    w_rdata = 32'd0;
    case (size)
      2'b00:   w_rdata = ld_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_rdata = ld_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      2'b10:   w_rdata = w_word;
      default: w_rdata = 32'd0;
    endcase
  end

  // Array has no reset; contents persist across rst.
  always_ff @(posedge clk) begin
    if (w_store) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      ready    <= 1'b0;
      err      <= 1'b0;
      mem_read <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          ready    <= 1'b0;
          err      <= 1'b0;
          mem_read <= 32'd0;
          if (w_accept) begin
            r_state  <= S_RESP;
            ready    <= 1'b1;
            err      <= w_err;
            mem_read <= (!wr_en && !w_err) ? w_rdata : 32'd0;
          end
        end
        S_RESP: begin
          r_state  <= S_IDLE;
          ready    <= 1'b0;
          err      <= 1'b0;
          mem_read <= 32'd0;
        end
        default: begin
          r_state  <= S_IDLE;
          ready    <= 1'b0;
          err      <= 1'b0;
          mem_read <= 32'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
